// File: rtl/vec_load_unit.sv
// Vector load unit: gathers DEPTH lanes from a synchronous word memory, one read per cycle.
// Optional feature macro VLU_STRIDE_EN adds a stride port; otherwise lanes are contiguous words.
module vec_load_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
`ifdef VLU_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      vec_out [0:DEPTH-1]
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [IdxW-1:0]       r_idx;
    logic [IdxW-1:0]       r_rd_idx;
    logic                  r_rd_pend;
    logic                  r_done;
    logic [WIDTH-1:0]      r_vec [0:DEPTH-1];
    logic                  w_accept;
    logic                  w_last_issue;

    assign w_accept     = (r_state == StIdle) && start;
    assign w_last_issue = (r_state == StFetch) && (r_idx == LastIdx);

`ifdef VLU_STRIDE_EN
    logic [ADDR_WIDTH-1:0] r_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= '0;
        end else if (w_accept) begin
            r_step <= stride;
        end
    end

    assign w_step = r_step;
`else
    assign w_step = ADDR_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StFetch;
            StFetch: if (r_idx == LastIdx) w_state_next = StDrain;
            StDrain: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Read data returns one cycle after the issue, so capture lags the issue by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr <= '0;
            r_idx      <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_idx   <= '0;
            r_done     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_vec[i] <= '0;
            end
        end else begin
            r_done    <= (r_state == StDrain);
            r_rd_pend <= (r_state == StFetch);
            r_rd_idx  <= r_idx;
            if (w_accept) begin
                r_mem_addr <= base_addr;
                r_idx      <= '0;
            end else if ((r_state == StFetch) && !w_last_issue) begin
                r_mem_addr <= r_mem_addr + w_step;
                r_idx      <= r_idx + 1'b1;
            end
            if (r_rd_pend) begin
                r_vec[r_rd_idx] <= mem_rdata;
            end
        end
    end

    assign mem_rd_en = (r_state == StFetch);
    assign mem_addr  = r_mem_addr;
    assign busy      = (r_state != StIdle);
    assign done      = r_done;
    assign vec_out   = r_vec;

endmodule

// File: tb/tb_vec_load_unit.sv
// Scoreboard bench for vec_load_unit: driver pushes expected addresses/vectors, monitor checks.
// Build with VLU_STRIDE_EN defined to exercise the stride port.
module tb_vec_load_unit;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
`ifdef VLU_STRIDE_EN
    logic [AW-1:0] stride;
`endif
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  vec_out [0:D-1];

    vec_load_unit #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
`ifdef VLU_STRIDE_EN
        .stride    (stride),
`endif
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .vec_out   (vec_out)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [logic [AW-1:0]];

    function automatic logic [W-1:0] mem_read(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_read(mem_addr);
    end

    // Reference model state
    logic [AW-1:0]    exp_addr_q [$];
    logic [D*W-1:0]   exp_vec_q  [$];
    int               busy_left = 0;
    logic             busy_exp  = 1'b0;
    logic             done_exp  = 1'b0;
    logic [AW-1:0]    hold_exp  = '0;
    logic             mon_en    = 1'b0;
    int               checks    = 0;
    int               errors    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_step(input logic rst, input logic st, input logic [AW-1:0] b,
                              input logic [AW-1:0] s);
        logic [AW-1:0]  step;
        logic [AW-1:0]  a;
        logic [D*W-1:0] v;
        done_exp = 1'b0;
        if (rst) begin
            busy_left = 0;
            exp_addr_q.delete();
            exp_vec_q.delete();
            hold_exp = '0;
        end else if (busy_left > 0) begin
            busy_left--;
            done_exp = (busy_left == 0);
        end else if (st) begin
`ifdef VLU_STRIDE_EN
            step = s;
`else
            step = (s == s) ? 32'd1 : 32'd1;
`endif
            v = '0;
            for (int k = 0; k < D; k++) begin
                a = b + AW'(k) * step;
                exp_addr_q.push_back(a);
                v[k*W +: W] = mem_read(a);
                hold_exp = a;
            end
            exp_vec_q.push_back(v);
            busy_left = D + 1;
        end
        busy_exp = (busy_left > 0);
    endtask

    task automatic cycle(input logic rst, input logic st, input logic [AW-1:0] b,
                         input logic [AW-1:0] s);
        reset     = rst;
        start     = st;
        base_addr = b;
`ifdef VLU_STRIDE_EN
        stride    = s;
`endif
        @(posedge clk);
        model_step(rst, st, b, s);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        for (int k = 0; k < D; k++) chk($sformatf("%s_lane%0d", tag, k), 64'(vec_out[k]), 64'd0);
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [AW-1:0]  ea;
        logic [D*W-1:0] ev;
        if (mon_en) begin
            chk("busy", 64'(busy), 64'(busy_exp));
            chk("done", 64'(done), 64'(done_exp));
            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_read", 64'(mem_addr), 64'hDEAD);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(ea));
                end
            end else begin
                chk("mem_addr_hold", 64'(mem_addr), 64'(hold_exp));
            end
            if (done) begin
                if (exp_vec_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    ev = exp_vec_q.pop_front();
                    for (int k = 0; k < D; k++)
                        chk($sformatf("lane%0d", k), 64'(vec_out[k]), 64'(ev[k*W +: W]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          rst;
        logic          st;
        logic [AW-1:0] b;
        logic [AW-1:0] s;
        reset = 1'b1; start = 1'b1; base_addr = '0;
`ifdef VLU_STRIDE_EN
        stride = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            mem[32'h10 + i] = 32'hA0 + i;
            mem[32'h20 + i] = 32'hB0 + i;
        end

        // Reset with start held high
        cycle(1'b1, 1'b1, 32'h10, 32'h1);
        cycle(1'b1, 1'b1, 32'h10, 32'h1);
        check_cleared("reset");
        mon_en = 1'b1;

        // Basic contiguous load
        cycle(1'b0, 1'b1, 32'h10, 32'h1);
        idle(8);

        // Start re-pulsed at E2 must be ignored
        cycle(1'b0, 1'b1, 32'h10, 32'h1);
        idle(1);
        cycle(1'b0, 1'b1, 32'h30, 32'h1);
        idle(8);

        // Back-to-back: second start in the done cycle
        cycle(1'b0, 1'b1, 32'h10, 32'h1);
        idle(5);
        cycle(1'b0, 1'b1, 32'h20, 32'h1);
        idle(8);

        // Address wrap-around
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h1);
        idle(8);

        // Reset at E2 of a load aborts it
        cycle(1'b0, 1'b1, 32'h50, 32'h1);
        idle(1);
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        check_cleared("abort");
        idle(8);

`ifdef VLU_STRIDE_EN
        cycle(1'b0, 1'b1, 32'h40, 32'd3);
        idle(8);
        cycle(1'b0, 1'b1, 32'h40, 32'd0);
        idle(8);
`endif

        // Random traffic including spurious starts and occasional resets
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            st  = ($urandom_range(0, 2) == 0);
            b   = $urandom;
            s   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 4);
            cycle(rst, st, b, s);
        end

        idle(12);
        chk("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        chk("vec_q_empty", 64'(exp_vec_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
